// File: rtl/register_bank_pkg.sv
// Shared datapath definitions for the register bank and its scoreboard.
// Register address width, the hardwired zero register and default widths.
package register_bank_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_SPACE  = 1 << REG_ADDR_W;
   localparam int CNT_W      = REG_ADDR_W + 1;
   localparam int DEF_DATA_W = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

   // One set or clear request into the pending scoreboard.
   typedef struct packed {
      logic      en;
      reg_addr_t idx;
   } sb_req_t;

   // A request only matters when enabled and not aimed at r0.
   function automatic logic req_hits(input sb_req_t r);
      return r.en && (r.idx != REG_ZERO);
   endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Destination-pending scoreboard: one pending bit per register plus a
// registered population count. A set beats a clear on the same register.
module regbank_scoreboard
   import register_bank_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  sb_req_t              set_req,
   input  sb_req_t              clr_req,
   output logic [REG_SPACE-1:0] pending,
   output logic [CNT_W-1:0]     pend_cnt
);

   logic [REG_SPACE-1:0] pend_d, pend_q;
   logic [CNT_W-1:0]     cnt_d, cnt_q;
   logic                 set_hit, clr_hit;
   logic                 same_reg, inc, dec;

   // Next pending bits and count; set applied after clear so it wins.
   always_comb begin
      set_hit  = req_hits(set_req);
      clr_hit  = req_hits(clr_req);
      same_reg = set_hit && clr_hit
                 && (set_req.idx == clr_req.idx);
      inc      = set_hit && !pend_q[set_req.idx];
      dec      = clr_hit && pend_q[clr_req.idx] && !same_reg;
      pend_d   = pend_q;
      if (clr_hit) begin
         pend_d[clr_req.idx] = 1'b0;
      end
      if (set_hit) begin
         pend_d[set_req.idx] = 1'b1;
      end
      pend_d[0] = 1'b0;
      cnt_d     = cnt_q;
      if (inc && !dec) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (dec && !inc) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Pending state register; reset drops every outstanding producer.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   assign pending  = pend_q;
   assign pend_cnt = cnt_q;

endmodule

// File: rtl/register_bank.sv
// Register file with pending-destination scoreboard and two async reads.
// Define REGBANK_WB_BYPASS_EN to forward same-cycle WB data to the reads.
module register_bank
   import register_bank_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NREGS  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] rs_addr,
   input  logic [REG_ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0]     rs_data,
   output logic [DATA_W-1:0]     rt_data,
   output logic                  rs_busy,
   output logic                  rt_busy,
   input  logic                  iss_valid,
   input  logic [REG_ADDR_W-1:0] iss_dest,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_dest,
   input  logic [DATA_W-1:0]     wb_data,
   output logic [CNT_W-1:0]      pend_cnt
);

   logic [DATA_W-1:0]    mem_d [NREGS];
   logic [DATA_W-1:0]    mem_q [NREGS];
   logic [REG_SPACE-1:0] pending;
   sb_req_t              set_req, clr_req;
   logic                 wb_wr;

   function automatic logic in_range(input reg_addr_t a);
      return (int'(a) < NREGS) && (a != REG_ZERO);
   endfunction

   // Scoreboard requests; addresses past NREGS are not real registers.
   always_comb begin
      set_req.en  = iss_valid && in_range(iss_dest);
      set_req.idx = iss_dest;
      clr_req.en  = wb_en && in_range(wb_dest);
      clr_req.idx = wb_dest;
      wb_wr       = clr_req.en;
   end

   regbank_scoreboard u_sb (
      .clk      (clk),
      .reset    (reset),
      .set_req  (set_req),
      .clr_req  (clr_req),
      .pending  (pending),
      .pend_cnt (pend_cnt)
   );

   // Next storage contents: a single WB write port.
   always_comb begin
      mem_d = mem_q;
      if (wb_wr) begin
         mem_d[wb_dest] = wb_data;
      end
   end

   // Storage array; reset clears every entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   // Async read ports; r0 and out-of-range addresses read as zero.
   always_comb begin
      rs_data = '0;
      rt_data = '0;
      if (in_range(rs_addr)) begin
         rs_data = mem_q[rs_addr];
      end
      if (in_range(rt_addr)) begin
         rt_data = mem_q[rt_addr];
      end
      rs_busy = pending[rs_addr];
      rt_busy = pending[rt_addr];
`ifdef REGBANK_WB_BYPASS_EN
      if (wb_wr && (rs_addr == wb_dest)) begin
         rs_data = wb_data;
         if (!(set_req.en && (iss_dest == rs_addr))) begin
            rs_busy = 1'b0;
         end
      end
      if (wb_wr && (rt_addr == wb_dest)) begin
         rt_data = wb_data;
         if (!(set_req.en && (iss_dest == rt_addr))) begin
            rt_busy = 1'b0;
         end
      end
`endif
   end

endmodule

// File: tb/tb_register_bank.sv
// Table-driven bench for register_bank with an expectation queue and a
// small reference model driving a randomized tail.
module tb_register_bank;

   localparam bit BYP =
`ifdef REGBANK_WB_BYPASS_EN
      1'b1;
`else
      1'b0;
`endif

   typedef struct {
      bit          chk;
      logic        rst;
      logic        iv;
      logic [4:0]  id;
      logic        we;
      logic [4:0]  wd;
      logic [31:0] wdat;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] ersd;
      logic [31:0] ertd;
      logic        ersb;
      logic        ertb;
      logic [5:0]  ecnt;
   } vec_t;

   typedef struct {
      logic [31:0] rsd;
      logic [31:0] rtd;
      logic        rsb;
      logic        rtb;
      logic [5:0]  cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs_addr, rt_addr;
   logic [31:0] rs_data, rt_data;
   logic        rs_busy, rt_busy;
   logic        iss_valid;
   logic [4:0]  iss_dest;
   logic        wb_en;
   logic [4:0]  wb_dest;
   logic [31:0] wb_data;
   logic [5:0]  pend_cnt;

   int n_cmp = 0;
   int n_err = 0;

   exp_t expq[$];
   vec_t tbl[$];

   logic [31:0] m_mem [32];
   bit          m_pend [32];

   always #5 clk = ~clk;

   register_bank dut (
      .clk       (clk),
      .reset     (reset),
      .rs_addr   (rs_addr),
      .rt_addr   (rt_addr),
      .rs_data   (rs_data),
      .rt_data   (rt_data),
      .rs_busy   (rs_busy),
      .rt_busy   (rt_busy),
      .iss_valid (iss_valid),
      .iss_dest  (iss_dest),
      .wb_en     (wb_en),
      .wb_dest   (wb_dest),
      .wb_data   (wb_data),
      .pend_cnt  (pend_cnt)
   );

   function automatic vec_t mk(
      bit c, logic r, logic iv, logic [4:0] id,
      logic we, logic [4:0] wd, logic [31:0] wdat,
      logic [4:0] ra, logic [4:0] rb,
      logic [31:0] ersd, logic [31:0] ertd,
      logic ersb, logic ertb, logic [5:0] ecnt);
      vec_t v;
      v.chk = c; v.rst = r; v.iv = iv; v.id = id;
      v.we = we; v.wd = wd; v.wdat = wdat;
      v.ra = ra; v.rb = rb; v.ersd = ersd; v.ertd = ertd;
      v.ersb = ersb; v.ertb = ertb; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic cmp(string nm, int idx,
                      logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s step %0d: got %h, expected %h",
                  nm, idx, act, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         m_mem[i]  = '0;
         m_pend[i] = 1'b0;
      end
   endfunction

   function automatic int model_cnt();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
      return c;
   endfunction

   function automatic void model_read(input vec_t v, input logic [4:0] a,
                                      output logic [31:0] d,
                                      output logic b);
      d = m_mem[a];
      b = m_pend[a];
      if (BYP && v.we && v.wd != 0 && v.wd == a) begin
         d = v.wdat;
         if (!(v.iv && v.id == a)) b = 1'b0;
      end
   endfunction

   function automatic void model_fill(inout vec_t v);
      model_read(v, v.ra, v.ersd, v.ersb);
      model_read(v, v.rb, v.ertd, v.ertb);
      v.ecnt = 6'(model_cnt());
   endfunction

   function automatic void model_edge(input vec_t v);
      if (v.rst) begin
         model_reset();
      end else begin
         if (v.we && v.wd != 0) begin
            m_mem[v.wd]  = v.wdat;
            m_pend[v.wd] = 1'b0;
         end
         if (v.iv && v.id != 0) m_pend[v.id] = 1'b1;
      end
   endfunction

   // Drive one cycle, queue its expectation, check mid-cycle.
   task automatic run_cycle(input vec_t v, input int idx);
      exp_t e;
      reset     = v.rst;
      iss_valid = v.iv;
      iss_dest  = v.id;
      wb_en     = v.we;
      wb_dest   = v.wd;
      wb_data   = v.wdat;
      rs_addr   = v.ra;
      rt_addr   = v.rb;
      if (v.chk) begin
         e.rsd = v.ersd; e.rtd = v.ertd;
         e.rsb = v.ersb; e.rtb = v.ertb; e.cnt = v.ecnt;
         expq.push_back(e);
      end
      @(negedge clk);
      if (v.chk) begin
         if (expq.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL queue step %0d: empty, expected 1 entry", idx);
         end else begin
            e = expq.pop_front();
            cmp("rs_data", idx, rs_data, e.rsd);
            cmp("rt_data", idx, rt_data, e.rtd);
            cmp("rs_busy", idx, 32'(rs_busy), 32'(e.rsb));
            cmp("rt_busy", idx, 32'(rt_busy), 32'(e.rtb));
            cmp("pend_cnt", idx, 32'(pend_cnt), 32'(e.cnt));
         end
      end
      @(posedge clk);
      model_edge(v);
      #1;
   endtask

   initial begin
      vec_t v;
      reset = 1'b1; iss_valid = 1'b0; iss_dest = '0;
      wb_en = 1'b0; wb_dest = '0; wb_data = '0;
      rs_addr = '0; rt_addr = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // reset state, issue/writeback, r0, set+clear, bypass
      tbl.push_back(mk(1,0, 0,0, 0,0,0, 5,31, 0,0,0,0, 0));
      tbl.push_back(mk(1,0, 1,8, 0,0,0, 8,0, 0,0,0,0, 0));
      tbl.push_back(mk(1,0, 0,0, 0,0,0, 8,8, 0,0,1,1, 1));
      tbl.push_back(mk(1,0, 0,0, 1,8,32'hCAFEF00D, 8,0,
                       BYP ? 32'hCAFEF00D : 32'h0, 0,
                       !BYP, 0, 1));
      tbl.push_back(mk(1,0, 0,0, 0,0,0, 8,8,
                       32'hCAFEF00D,32'hCAFEF00D,0,0, 0));
      tbl.push_back(mk(1,0, 1,0, 1,0,32'hFFFFFFFF, 0,0, 0,0,0,0, 0));
      tbl.push_back(mk(1,0, 0,0, 0,0,0, 0,8, 0,32'hCAFEF00D,0,0, 0));
      tbl.push_back(mk(1,0, 1,9, 0,0,0, 9,9, 0,0,0,0, 0));
      tbl.push_back(mk(1,0, 1,9, 1,9,32'h7, 9,9,
                       BYP ? 32'h7 : 32'h0, BYP ? 32'h7 : 32'h0,
                       1,1, 1));
      tbl.push_back(mk(1,0, 0,0, 0,0,0, 9,9, 7,7,1,1, 1));
      tbl.push_back(mk(1,0, 0,0, 1,9,32'h11, 9,3,
                       BYP ? 32'h11 : 32'h7, 0, !BYP, 0, 1));
      tbl.push_back(mk(1,0, 1,3, 0,0,0, 9,3, 32'h11,0,0,0, 0));
      tbl.push_back(mk(1,0, 0,0, 1,3,32'hA5A5A5A5, 0,3,
                       0, BYP ? 32'hA5A5A5A5 : 32'h0, 0, !BYP, 1));
      tbl.push_back(mk(1,0, 0,0, 0,0,0, 3,9,
                       32'hA5A5A5A5,32'h11,0,0, 0));

      // reset mid-operation with pending state and ignored inputs
      tbl.push_back(mk(1,0, 1,7, 1,5,32'h1234, 5,7,
                       BYP ? 32'h1234 : 32'h0, 0,0,0, 0));
      tbl.push_back(mk(1,0, 0,0, 0,0,0, 5,7, 32'h1234,0,0,1, 1));
      tbl.push_back(mk(0,1, 1,6, 1,6,32'h55, 0,0, 0,0,0,0, 0));
      tbl.push_back(mk(1,0, 0,0, 0,0,0, 5,7, 0,0,0,0, 0));
      tbl.push_back(mk(1,0, 0,0, 0,0,0, 6,8, 0,0,0,0, 0));

      // saturation: r1..r31 back to back
      for (int i = 1; i < 32; i++) begin
         tbl.push_back(mk(1,0, 1,5'(i), 0,0,0, 5'(i),5'(i-1),
                          0,0,0,(i > 1), 6'(i-1)));
      end
      tbl.push_back(mk(1,0, 0,0, 1,0,32'hFFFF, 31,1, 0,0,1,1, 31));
      tbl.push_back(mk(1,0, 0,0, 1,4,32'h44, 4,0,
                       BYP ? 32'h44 : 32'h0, 0, !BYP, 0, 31));
      tbl.push_back(mk(1,0, 0,0, 1,4,32'h45, 4,0,
                       BYP ? 32'h45 : 32'h44, 0,0,0, 30));
      tbl.push_back(mk(1,0, 1,1, 0,0,0, 4,1, 32'h45,0,0,1, 30));
      tbl.push_back(mk(1,0, 0,0, 0,0,0, 1,31, 0,0,1,1, 30));

      foreach (tbl[i]) run_cycle(tbl[i], i);

      // randomized tail checked against the reference model
      for (int i = 0; i < 300; i++) begin
         v = mk(1, ($urandom_range(0, 49) == 0),
                $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                $urandom, 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 0,0,0,0, 0);
         model_fill(v);
         run_cycle(v, 1000 + i);
      end

      if (expq.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL queue drain: %0d left, expected 0", expq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
